// File: rtl/mips_muldiv_pkg.sv
// Shared types and sizing helpers for the MIPS multiply/divide unit.
package mips_muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Iteration counter width for a given operand width (at least one bit).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int MD_CNT_W = cnt_width(MD_WIDTH);

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the unsigned shift-add multiplier / restoring divider.
// Multiply: {acc, sh} is the partial product, sh starts as the multiplier.
// Divide:   {acc, sh} is the partial remainder, sh collects quotient bits.
module mips_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] sh_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] sh_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           fits;

    // Select between add-and-shift-right and shift-left-and-trial-subtract.
    always_comb begin
        sum     = {1'b0, acc_i} + (sh_i[0] ? {1'b0, opnd_i} : '0);
        shifted = {acc_i, sh_i[WIDTH-1]};
        fits    = (shifted >= {1'b0, opnd_i});
        acc_o   = sum[WIDTH:1];
        sh_o    = {sum[0], sh_i[WIDTH-1:1]};
        if (is_div_i) begin
            // Remainder stays below the divisor, so the difference fits WIDTH bits.
            acc_o = fits ? WIDTH'(shifted - {1'b0, opnd_i}) : shifted[WIDTH-1:0];
            sh_o  = {sh_i[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO pair.
// Operates on magnitudes for WIDTH cycles, then a single FIX cycle applies
// signs and writes HI/LO. MTHI/MTLO writes abort any operation in flight.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic [WIDTH-1:0]   acc_q, sh_q, opnd_q, dvd_q;
    logic               is_div_q, neg_res_q, neg_rem_q, div0_q;

    op_e                op_sel;
    logic               is_div, is_signed, a_neg, b_neg, wr_any, accept;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   acc_nxt, sh_nxt;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign op_sel    = op_e'(op);
    assign is_div    = (op_sel == OP_DIV) || (op_sel == OP_DIVU);
    assign is_signed = (op_sel == OP_MULT) || (op_sel == OP_DIV);
    assign a_neg     = is_signed & rs_data[WIDTH-1];
    assign b_neg     = is_signed & rt_data[WIDTH-1];
    assign a_mag     = a_neg ? -rs_data : rs_data;
    assign b_mag     = b_neg ? -rt_data : rt_data;
    assign wr_any    = hi_write | lo_write;
    assign accept    = (state_q == S_IDLE) && start;

    mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .sh_i     (sh_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_nxt),
        .sh_o     (sh_nxt)
    );

    // Sign correction and special-case mapping of the final magnitudes.
    always_comb begin
        prod     = {acc_q, sh_q};
        prod_fix = neg_res_q ? -prod : prod;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (div0_q) begin
                fix_hi = dvd_q;
                fix_lo = '1;
            end else begin
                fix_hi = neg_rem_q ? -acc_q : acc_q;
                fix_lo = neg_res_q ? -sh_q : sh_q;
            end
        end
    end

    // Datapath: load magnitudes on accept, iterate while running.
    always_ff @(posedge clk) begin
        if (clk_enable) begin
            if (accept) begin
                acc_q     <= '0;
                sh_q      <= is_div ? a_mag : b_mag;
                opnd_q    <= is_div ? b_mag : a_mag;
                dvd_q     <= rs_data;
                is_div_q  <= is_div;
                neg_res_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                div0_q    <= (rt_data == '0);
            end else if (state_q == S_RUN) begin
                acc_q <= acc_nxt;
                sh_q  <= sh_nxt;
            end
        end
    end

    // Control FSM with registered busy/done and the architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (clk_enable) begin
            done_q <= 1'b0;
            if (hi_write) hi_q <= wr_data;
            if (lo_write) lo_q <= wr_data;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_q   <= CNT_W'(WIDTH - 1);
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (wr_any) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (!wr_any) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit with a cycle-level reference model.
module tb_mips_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, clk_enable, start, hi_write, lo_write;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data, wr_data;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int e0     = 0;
    bit chk_en = 1'b0;

    // reference model state
    logic        m_busy, m_done;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          m_rem;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
        .op(op), .rs_data(rs_data), .rt_data(rt_data),
        .hi_write(hi_write), .lo_write(lo_write), .wr_data(wr_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: actual cycle %0d required completion", cyc);
        $fatal(1, "bench timeout");
    end

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    // Architectural result: {HI, LO}.
    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            2'd0: return 64'(sa * sb);
            2'd1: return ua * ub;
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Timing model: result lands WIDTH+1 edges after acceptance.
    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; m_rem <= 0;
        end else if (clk_enable) begin
            m_done <= 1'b0;
            if (m_busy && (hi_write || lo_write)) begin
                m_busy <= 1'b0;
                if (hi_write) m_hi <= wr_data;
                if (lo_write) m_lo <= wr_data;
            end else if (m_busy) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    {m_hi, m_lo} <= m_res;
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end else begin
                if (hi_write) m_hi <= wr_data;
                if (lo_write) m_lo <= wr_data;
                if (start) begin
                    m_res  <= ref_op(op, rs_data, rt_data);
                    m_busy <= 1'b1;
                    m_rem  <= 33;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
            check("cyc_done", {31'b0, done}, {31'b0, m_done});
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        tick();
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        bit seen = 1'b0;
        busy_n = busy ? 1 : 0;
        lat = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
                lat = cyc - e0;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic watch_no_done(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check(nm, {31'b0, seen}, 32'd0);
    endtask

    int lat, bn;

    initial begin
        reset = 1'b1; clk_enable = 1'b1; start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
        op = 2'd0; rs_data = '0; rt_data = '0; wr_data = '0;
        tick(); tick();
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);

        // MULT -3 * 5
        issue(2'd0, 32'hFFFFFFFD, 32'd5);
        check("mult_busy_e0", {31'b0, busy}, 32'd1);
        wait_done(lat, bn);
        check("mult_latency", 32'(lat), 32'd33);
        check("mult_busy_cycles", 32'(bn), 32'd33);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFF1);

        // MULTU max * max
        issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, bn);
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);

        // DIV -7 / 2
        issue(2'd2, 32'hFFFFFFF9, 32'd2);
        wait_done(lat, bn);
        check("div_lat", 32'(lat), 32'd33);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        // DIVU 100 / 0
        issue(2'd3, 32'd100, 32'd0);
        wait_done(lat, bn);
        check("div0_lat", 32'(lat), 32'd33);
        check("div0_lo", lo, 32'hFFFFFFFF);
        check("div0_hi", hi, 32'h00000064);

        // DIV most-negative / -1
        issue(2'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat, bn);
        check("ovf_lo", lo, 32'h80000000);
        check("ovf_hi", hi, 32'h0);

        // DIVU 100 / 7 with an ignored MULT start while busy
        issue(2'd3, 32'd100, 32'd7);
        tick(); tick(); tick();
        op = 2'd0; rs_data = 32'd2; rt_data = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, bn);
        check("ign_lat", 32'(lat), 32'd33);
        check("ign_lo", lo, 32'd14);
        check("ign_hi", hi, 32'd2);

        // clk_enable low for 5 cycles mid-run delays done by 5
        issue(2'd1, 32'd7, 32'd9);
        for (int i = 0; i < 10; i++) tick();
        clk_enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        clk_enable = 1'b1;
        wait_done(lat, bn);
        check("stall_lat", 32'(lat), 32'd38);
        check("stall_lo", lo, 32'd63);
        check("stall_hi", hi, 32'd0);

        // MTHI on cycle 10 of a MULT aborts it
        issue(2'd0, 32'h100, 32'h200);
        for (int i = 0; i < 8; i++) tick();
        hi_write = 1'b1; wr_data = 32'h1234;
        tick();
        hi_write = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, 32'h1234);
        check("abort_lo", lo, 32'd63);
        watch_no_done("abort_no_done");

        // MTLO while idle
        lo_write = 1'b1; wr_data = 32'hABCD;
        tick();
        lo_write = 1'b0;
        check("mtlo_lo", lo, 32'hABCD);
        check("mtlo_hi", hi, 32'h1234);

        // MTHI together with start: write first, result overwrites later
        hi_write = 1'b1; wr_data = 32'h5555;
        issue(2'd1, 32'd3, 32'd4);
        hi_write = 1'b0;
        check("both_hi_now", hi, 32'h5555);
        check("both_busy", {31'b0, busy}, 32'd1);
        wait_done(lat, bn);
        check("both_hi", hi, 32'd0);
        check("both_lo", lo, 32'd12);

        // reset at cycle 20 of a DIV
        issue(2'd2, 32'd1000, 32'd3);
        for (int i = 0; i < 18; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_hi", hi, 32'h0);
        check("mrst_lo", lo, 32'h0);
        check("mrst_busy", {31'b0, busy}, 32'd0);
        watch_no_done("mrst_no_done");

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
